// File: rtl/alu_share_if.sv
// alu_share_if: requester, ALU and status signals around the ALU share arbiter
// slave  : arbiter side (requests and alu_y in; ALU drive, result, done, busy out)
// master : environment side (requesters plus ALU result)
interface alu_share_if #(
  parameter int width = 4
);
  logic req0, req1;
  logic [width-1:0] a0, b0, a1, b1;
  logic [3:0] op0, op1;
  logic [width-1:0] alu_a, alu_b, alu_y, result;
  logic [3:0] alu_op;
  logic done0, done1, busy;
  modport slave (
    input req0, a0, b0, op0, req1, a1, b1, op1, alu_y,
    output alu_a, alu_b, alu_op, result, done0, done1, busy
  );
  modport master (
    output req0, a0, b0, op0, req1, a1, b1, op1, alu_y,
    input alu_a, alu_b, alu_op, result, done0, done1, busy
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin sharing of one registered ALU between two requesters
// clk   : system clock, all state on rising edge
// reset : asynchronous active-high, clears all state
// bus   : slave modport; req0/a0/b0/op0 and req1/a1/b1/op1 in, alu_a/alu_b/alu_op out,
//         alu_y in, result/done0/done1/busy out
module alu_share_arbiter #(
  parameter int width = 4,
  parameter int LAT = 2
) (
  input logic clk,
  input logic reset,
  alu_share_if.slave bus
);
  localparam int CW = $clog2(LAT + 1);
  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
  state_t state_q;
  logic [width-1:0] alu_a_q, alu_b_q, result_q, a_d, b_d;
  logic [3:0] alu_op_q, op_d;
  logic [CW-1:0] cnt_q;
  logic owner_q, last_q, done0_q, done1_q, win_d;
  // a contested grant goes to the requester that did not win last time
  always_comb begin
    win_d = bus.req1 & (~bus.req0 | ~last_q);
    a_d = win_d ? bus.a1 : bus.a0;
    b_d = win_d ? bus.b1 : bus.b0;
    op_d = win_d ? bus.op1 : bus.op0;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      alu_a_q <= '0;
      alu_b_q <= '0;
      alu_op_q <= '0;
      result_q <= '0;
      cnt_q <= '0;
      owner_q <= 1'b0;
      last_q <= 1'b1;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (bus.req0 | bus.req1) begin
          alu_a_q <= a_d;
          alu_b_q <= b_d;
          alu_op_q <= op_d;
          owner_q <= win_d;
          last_q <= win_d;
          cnt_q <= '0;
          state_q <= EXEC;
        end
        // operands stay put while cnt counts out the ALU pipeline
        EXEC: begin
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(LAT)) begin
            result_q <= bus.alu_y;
            done0_q <= ~owner_q;
            done1_q <= owner_q;
            state_q <= DONE;
          end
        end
        DONE: begin
          done0_q <= 1'b0;
          done1_q <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign bus.alu_a = alu_a_q;
  assign bus.alu_b = alu_b_q;
  assign bus.alu_op = alu_op_q;
  assign bus.result = result_q;
  assign bus.done0 = done0_q;
  assign bus.done1 = done1_q;
  assign bus.busy = state_q != IDLE;
endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: directed and random checks of alu_share_arbiter against a transaction model
module tb_alu_share_arbiter;
  localparam int LAT = 2;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  alu_share_if #(.width(4)) b4 ();
  alu_share_if #(.width(8)) b8 ();
  alu_share_arbiter #(.width(4), .LAT(2)) dut4 (.clk(clk), .reset(reset), .bus(b4));
  alu_share_arbiter #(.width(8), .LAT(3)) dut8 (.clk(clk), .reset(reset), .bus(b8));
  function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
    return op == 4'd0 ? a + b : op == 4'd1 ? a - b : op == 4'd2 ? a & b : op == 4'd3 ? a | b : op == 4'd4 ? a ^ b : a;
  endfunction
  logic [3:0] p4_a, p4_b, p4_op, y4;
  logic [7:0] t4, p8_a, p8_b, y8;
  logic [3:0] p8_op;
  assign t4 = alu_f({4'd0, p4_a}, {4'd0, p4_b}, p4_op);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p4_a <= '0; p4_b <= '0; p4_op <= '0; y4 <= '0;
      p8_a <= '0; p8_b <= '0; p8_op <= '0; y8 <= '0;
    end else begin
      p4_a <= b4.alu_a; p4_b <= b4.alu_b; p4_op <= b4.alu_op; y4 <= t4[3:0];
      p8_a <= b8.alu_a; p8_b <= b8.alu_b; p8_op <= b8.alu_op; y8 <= alu_f(p8_a, p8_b, p8_op);
    end
  end
  assign b4.alu_y = y4;
  assign b8.alu_y = y8;

  function automatic int ref_op(input int a, input int b, input int op, input int w);
    int m;
    m = 1 << w;
    case (op)
      0: return (a + b) % m;
      1: return (a - b + m) % m;
      2: return a & b;
      3: return a | b;
      4: return a ^ b;
      default: return a;
    endcase
  endfunction

  int tests = 0, fails = 0;
  int edge_n = 0, next_ok = 0, g_edge = -100, done_edge = -1, m_last = 1, m_owner = 0;
  int e_a = 0, e_b = 0, e_op = 0, e_res = 0, pend_res = 0;
  bit rnd_en = 1'b0, hold1 = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    int w;
    if (edge_n + 1 >= next_ok && (b4.req0 || b4.req1)) begin
      w = (b4.req1 && (!b4.req0 || m_last == 0)) ? 1 : 0;
      e_a = int'(w == 1 ? b4.a1 : b4.a0);
      e_b = int'(w == 1 ? b4.b1 : b4.b0);
      e_op = int'(w == 1 ? b4.op1 : b4.op0);
      pend_res = ref_op(e_a, e_b, e_op, 4);
      m_owner = w;
      m_last = w;
      g_edge = edge_n + 1;
      done_edge = g_edge + LAT + 1;
      next_ok = g_edge + LAT + 3;
    end
    @(posedge clk);
    edge_n++;
    @(negedge clk);
    if (edge_n == done_edge) e_res = pend_res;
    chk("busy", 32'(b4.busy), 32'(edge_n >= g_edge && edge_n < g_edge + LAT + 2));
    chk("done0", 32'(b4.done0), 32'(edge_n == done_edge && m_owner == 0));
    chk("done1", 32'(b4.done1), 32'(edge_n == done_edge && m_owner == 1));
    chk("alu_a", 32'(b4.alu_a), 32'(e_a));
    chk("alu_b", 32'(b4.alu_b), 32'(e_b));
    chk("alu_op", 32'(b4.alu_op), 32'(e_op));
    chk("result", 32'(b4.result), 32'(e_res));
    if (edge_n == done_edge) begin
      if (m_owner == 0) b4.req0 = 1'b0;
      else if (!hold1) b4.req1 = 1'b0;
    end else if (rnd_en) begin
      if (edge_n >= g_edge && edge_n < done_edge && $urandom_range(0, 3) == 0) begin
        if (m_owner == 0) begin b4.a0 = 4'($urandom); b4.b0 = 4'($urandom); end
        else begin b4.a1 = 4'($urandom); b4.b1 = 4'($urandom); end
      end
      if (!b4.req0 && $urandom_range(0, 2) == 0) begin
        b4.a0 = 4'($urandom); b4.b0 = 4'($urandom); b4.op0 = 4'($urandom_range(0, 7)); b4.req0 = 1'b1;
      end
      if (!b4.req1 && $urandom_range(0, 2) == 0) begin
        b4.a1 = 4'($urandom); b4.b1 = 4'($urandom); b4.op1 = 4'($urandom_range(0, 7)); b4.req1 = 1'b1;
      end
    end
  endtask

  task automatic do_reset();
    b4.req0 = 1'b0; b4.req1 = 1'b0; b8.req0 = 1'b0; b8.req1 = 1'b0; hold1 = 1'b0;
    reset = 1'b1;
    #2;
    chk("rst_alu_a", 32'(b4.alu_a), 32'(0));
    chk("rst_alu_b", 32'(b4.alu_b), 32'(0));
    chk("rst_alu_op", 32'(b4.alu_op), 32'(0));
    chk("rst_result", 32'(b4.result), 32'(0));
    chk("rst_done", 32'({b4.done0, b4.done1}), 32'(0));
    chk("rst_busy", 32'(b4.busy), 32'(0));
    chk("rst_busy8", 32'(b8.busy), 32'(0));
    reset = 1'b0;
    next_ok = 0; g_edge = -100; done_edge = -1; m_last = 1; m_owner = 0;
    e_a = 0; e_b = 0; e_op = 0; e_res = 0;
  endtask

  initial begin
    b4.req0 = 1'b0; b4.req1 = 1'b0; b4.a0 = '0; b4.b0 = '0; b4.op0 = '0; b4.a1 = '0; b4.b1 = '0; b4.op1 = '0;
    b8.req0 = 1'b0; b8.req1 = 1'b0; b8.a0 = '0; b8.b0 = '0; b8.op0 = '0; b8.a1 = '0; b8.b1 = '0; b8.op1 = '0;
    @(negedge clk);
    do_reset();
    b4.a0 = 4'd3; b4.b0 = 4'd5; b4.op0 = 4'd0; b4.req0 = 1'b1;
    step();
    chk("t1_alu_a", 32'(b4.alu_a), 32'(3));
    chk("t1_alu_b", 32'(b4.alu_b), 32'(5));
    repeat (3) step();
    chk("t1_done0", 32'(b4.done0), 32'(1));
    chk("t1_res", 32'(b4.result), 32'(8));
    chk("t1_done1", 32'(b4.done1), 32'(0));
    step();
    chk("t1_idle", 32'(b4.busy), 32'(0));
    do_reset();
    b4.a0 = 4'd3; b4.b0 = 4'd5; b4.op0 = 4'd0; b4.req0 = 1'b1;
    b4.a1 = 4'd9; b4.b1 = 4'd4; b4.op1 = 4'd1; b4.req1 = 1'b1;
    repeat (4) step();
    chk("t2_first0", 32'(b4.done0), 32'(1));
    repeat (5) step();
    chk("t2_done1", 32'(b4.done1), 32'(1));
    chk("t2_res1", 32'(b4.result), 32'(5));
    step();
    b4.req0 = 1'b1; b4.req1 = 1'b1;
    repeat (4) step();
    chk("t2_third0", 32'(b4.done0), 32'(1));
    repeat (5) step();
    do_reset();
    hold1 = 1'b1;
    b4.a1 = 4'd7; b4.b1 = 4'd2; b4.op1 = 4'd2; b4.req1 = 1'b1;
    repeat (2) step();
    b4.a0 = 4'd1; b4.b0 = 4'd1; b4.op0 = 4'd0; b4.req0 = 1'b1;
    repeat (7) step();
    chk("t3_done0", 32'(b4.done0), 32'(1));
    chk("t3_res0", 32'(b4.result), 32'(2));
    repeat (5) step();
    chk("t3_done1", 32'(b4.done1), 32'(1));
    do_reset();
    b4.a0 = 4'd3; b4.b0 = 4'd5; b4.op0 = 4'd0; b4.req0 = 1'b1;
    repeat (2) step();
    b4.a0 = 4'd15;
    repeat (2) step();
    chk("t4_done0", 32'(b4.done0), 32'(1));
    chk("t4_res", 32'(b4.result), 32'(8));
    do_reset();
    b4.a0 = 4'd6; b4.b0 = 4'd3; b4.op0 = 4'd1; b4.req0 = 1'b1;
    repeat (2) step();
    do_reset();
    repeat (6) step();
    chk("t5_idle", 32'(b4.busy), 32'(0));
    chk("t5_alu_op", 32'(b4.alu_op), 32'(0));
    b4.a0 = 4'd2; b4.b0 = 4'd6; b4.op0 = 4'd4; b4.req0 = 1'b1;
    repeat (4) step();
    chk("t5_res", 32'(b4.result), 32'(4));
    do_reset();
    rnd_en = 1'b1;
    repeat (400) step();
    rnd_en = 1'b0;
    do_reset();
    b8.a0 = 8'd200; b8.b0 = 8'd200; b8.op0 = 4'd0; b8.req0 = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("t6_done0", 32'(b8.done0), 32'(i == 5));
      chk("t6_done1", 32'(b8.done1), 32'(0));
      if (i == 5) begin
        chk("t6_res", 32'(b8.result), 32'(ref_op(200, 200, 0, 8)));
        b8.req0 = 1'b0;
      end
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
